// File: rtl/fixed_conv_arbiter.sv
// ----------------------------------------------------------------------------
// fixed_conv_arbiter
//
// Shares one float-to-fixed converter (IEEE-754 single in, 22-bit
// sign/1-int/20-frac out) between NREQ requesters. A round-robin arbiter
// grants one request per cycle while a credit is free. The granted operand
// is driven to the converter. A CONV_LAT-deep shift register follows each
// operation through the converter. Results enter an output FIFO in grant
// order.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester request valid              [NREQ]
//   req_ready    per-requester grant (one-hot or zero)     [NREQ]
//   req_data     operand of requester i at [32*i+:32]      [32*NREQ]
//   conv_data    operand to the shared converter           [32]
//   conv_result  converter output                          [22]
//   resp_valid   output FIFO non-empty
//   resp_ready   consumer accepts the head entry
//   resp_id      requester index of the head entry         [IDW]
//   resp_data    fixed-point result of the head entry      [22]
//   resp_zeroed  head operand was out of range (exp 0 or > 127)
//   idle         nothing in flight and FIFO empty
// ----------------------------------------------------------------------------
module fixed_conv_arbiter #(
  parameter int  NREQ     = 4,
  parameter int  CONV_LAT = 1,
  parameter int  DEPTH    = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [31:0]          conv_data,
  input  logic [21:0]          conv_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [21:0]          resp_data,
  output logic                 resp_zeroed,
  output logic                 idle
);

  localparam int CW = $clog2(DEPTH + 1);    // FIFO occupancy 0..DEPTH
  localparam int PW = $clog2(DEPTH);        // FIFO pointer
  localparam int LW = $clog2(CONV_LAT + 1); // in-flight count 0..CONV_LAT

  // ---------------------------------------------------------------- state
  logic [IDW-1:0]      r_rr;

  logic [CONV_LAT-1:0] r_stg_vld;
  logic [CONV_LAT-1:0] r_stg_zero;
  logic [IDW-1:0]      r_stg_id [CONV_LAT];

  logic [IDW-1:0]      r_fifo_id   [DEPTH];
  logic [21:0]         r_fifo_data [DEPTH];
  logic [DEPTH-1:0]    r_fifo_zero;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_fifo_cnt;

  // ---------------------------------------------------------------- wires
  logic [LW-1:0]       w_inflight_cnt;
  logic                w_credit;
  logic                w_gnt_found;
  logic [IDW-1:0]      w_gnt_id;
  logic [IDW:0]        w_scan_sum;
  logic [IDW-1:0]      w_scan_idx;
  logic [31:0]         w_gnt_data;
  logic [7:0]          w_gnt_exp;
  logic                w_gnt_zero;
  logic                w_hs;
  logic                w_push;
  logic                w_pop;

  // Number of valid shift-register stages.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < CONV_LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + LW'(r_stg_vld[i]);
    end
  end

  // Both counts are register values from the start of the cycle, so a pop
  // happening in this cycle does not free a credit until the next one.
  assign w_credit = (int'(w_inflight_cnt) + int'(r_fifo_cnt)) < DEPTH;

  // Round-robin scan from r_rr upward with wrap. The loop runs from the
  // farthest offset down so the nearest valid requester is written last.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_scan_sum  = '0;
    w_scan_idx  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_scan_sum = {1'b0, r_rr} + (IDW+1)'(off);
      if (w_scan_sum >= (IDW+1)'(NREQ)) begin
        w_scan_sum = w_scan_sum - (IDW+1)'(NREQ);
      end
      w_scan_idx = w_scan_sum[IDW-1:0];
      if (req_valid[w_scan_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_scan_idx;
      end
    end
  end

  // rst_n gates the grant so that nothing handshakes while reset is held.
  assign w_hs = w_gnt_found & w_credit & rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_hs && (w_gnt_id == IDW'(gi));
    end
  endgenerate

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_gnt_data = req_data[32*i +: 32];
      end
    end
  end

  assign w_gnt_exp  = w_gnt_data[30:23];
  assign w_gnt_zero = (w_gnt_exp == 8'd0) || (w_gnt_exp > 8'd127);
  assign conv_data  = w_hs ? w_gnt_data : 32'h0;

  // ------------------------------------------------------------- pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_hs) begin
      r_rr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // ------------------------------------------- in-flight shift register
  // An operation enters stage 0 on its handshake edge and leaves the last
  // stage CONV_LAT edges later, when conv_result belongs to it.
  generate
    for (gi = 0; gi < CONV_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_stg_vld[0]  <= 1'b0;
            r_stg_zero[0] <= 1'b0;
            r_stg_id[0]   <= '0;
          end else begin
            r_stg_vld[0]  <= w_hs;
            r_stg_zero[0] <= w_gnt_zero;
            r_stg_id[0]   <= w_gnt_id;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_stg_vld[gi]  <= 1'b0;
            r_stg_zero[gi] <= 1'b0;
            r_stg_id[gi]   <= '0;
          end else begin
            r_stg_vld[gi]  <= r_stg_vld[gi-1];
            r_stg_zero[gi] <= r_stg_zero[gi-1];
            r_stg_id[gi]   <= r_stg_id[gi-1];
          end
        end
      end
    end
  endgenerate

  // --------------------------------------------------------- output FIFO
  assign w_push     = r_stg_vld[CONV_LAT-1];
  assign resp_valid = (r_fifo_cnt != '0);
  assign w_pop      = resp_valid & resp_ready;

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= r_stg_id[CONV_LAT-1];
      r_fifo_data[r_wr_ptr] <= conv_result;
      r_fifo_zero[r_wr_ptr] <= r_stg_zero[CONV_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Head fields read as zero whenever the FIFO is empty, including reset.
  assign resp_id     = resp_valid ? r_fifo_id[r_rd_ptr]   : '0;
  assign resp_data   = resp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign resp_zeroed = resp_valid ? r_fifo_zero[r_rd_ptr] : 1'b0;

  assign idle = (w_inflight_cnt == '0) && (r_fifo_cnt == '0);

endmodule
